// File: rtl/if_fetch_sequencer_pkg.sv
// Shared encodings for the instruction-fetch sequencer: next-PC selects, FSM states, IF/ID layout.
package if_fetch_sequencer_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HALT_PEND = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_sequencer_pc_next_sel.sv
// Next-PC selection: wrapping PC+4 adder, 4:1 target mux and word alignment.
module if_fetch_sequencer_pc_next_sel
  import if_fetch_sequencer_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pcsrc,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_jr_target,
  input  logic [31:0] i_j_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_pc_next
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_raw_target;

  assign w_pc_plus4 = i_pc + 32'd4;

  always_comb begin
    w_raw_target = w_pc_plus4;
    case (i_pcsrc)
      PCSRC_SEQ: w_raw_target = w_pc_plus4;
      PCSRC_BR:  w_raw_target = i_br_target;
      PCSRC_JR:  w_raw_target = i_jr_target;
      PCSRC_J:   w_raw_target = i_j_target;
      default:   w_raw_target = w_pc_plus4;
    endcase
  end

  assign o_pc_plus4 = w_pc_plus4;
  assign o_pc_next  = align_word(w_raw_target);

endmodule

// File: rtl/if_fetch_sequencer.sv
// Fetch-stage sequencer: PC register, IF/ID register, stall/flush handling and debug halt FSM.
module if_fetch_sequencer
  import if_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] I_jump_PC,
  input  logic [31:0] ID_Qa,
  input  logic [31:0] J_jump_PC,
  input  logic        Stall,
  input  logic        Halt_req,
  input  logic        Resume,
  input  logic [31:0] IF_Inst,
  output logic [31:0] PC,
  output logic [31:0] ID_Inst,
  output logic [31:0] ID_PC_plus4,
  output logic        ID_Valid,
  output logic        Halted,
  output logic [31:0] Fetch_count
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  ifid_t       r_ifid;
  logic        r_halted;
  logic [31:0] r_fetch_count;

  logic [1:0]  w_state_d;
  logic [31:0] w_pc_d;
  ifid_t       w_ifid_d;
  logic [31:0] w_fetch_count_d;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_redirect;
  logic        w_halted_st;
  logic        w_advance;

  if_fetch_sequencer_pc_next_sel u_pc_next_sel (
    .i_pc        (r_pc),
    .i_pcsrc     (Pcsrc),
    .i_br_target (I_jump_PC),
    .i_jr_target (ID_Qa),
    .i_j_target  (J_jump_PC),
    .o_pc_plus4  (w_pc_plus4),
    .o_pc_next   (w_pc_next)
  );

  assign w_redirect  = (Pcsrc != PCSRC_SEQ);
  assign w_halted_st = (r_state == ST_HALTED);
  // HALT_PEND advances exactly like RUN; only HALTED and stalls freeze the PC.
  assign w_advance   = !w_halted_st && !Stall;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_RUN: begin
        if (Halt_req) begin
          w_state_d = Stall ? ST_HALT_PEND : ST_HALTED;
        end
      end
      ST_HALT_PEND: begin
        if (!Stall) begin
          w_state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (Resume && !Halt_req) begin
          w_state_d = ST_RUN;
        end
      end
      default: w_state_d = ST_RUN;
    endcase
  end

  always_comb begin
    w_pc_d          = r_pc;
    w_ifid_d        = r_ifid;
    w_fetch_count_d = r_fetch_count;
    if (w_halted_st) begin
      // Drain: keep feeding bubbles while the PC is frozen.
      w_ifid_d.inst  = NOP_INST;
      w_ifid_d.valid = 1'b0;
    end else if (w_advance) begin
      w_pc_d            = w_pc_next;
      w_ifid_d.pc_plus4 = w_pc_plus4;
      if (w_redirect) begin
        w_ifid_d.inst  = NOP_INST;
        w_ifid_d.valid = 1'b0;
      end else begin
        w_ifid_d.inst   = IF_Inst;
        w_ifid_d.valid  = 1'b1;
        w_fetch_count_d = r_fetch_count + 32'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_ifid.inst   <= NOP_INST;
      r_ifid.pc_plus4 <= 32'h0000_0000;
      r_ifid.valid  <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_ifid        <= w_ifid_d;
      r_halted      <= (w_state_d == ST_HALTED);
      r_fetch_count <= w_fetch_count_d;
    end
  end

  assign PC          = r_pc;
  assign ID_Inst     = r_ifid.inst;
  assign ID_PC_plus4 = r_ifid.pc_plus4;
  assign ID_Valid    = r_ifid.valid;
  assign Halted      = r_halted;
  assign Fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Directed bench for if_fetch_sequencer with a reference model feeding a scoreboard queue.
module tb_if_fetch_sequencer;

  localparam logic [31:0] IMEM_KEY = 32'h1357_9BDF;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [1:0]  Pcsrc;
  logic [31:0] I_jump_PC;
  logic [31:0] ID_Qa;
  logic [31:0] J_jump_PC;
  logic        Stall;
  logic        Halt_req;
  logic        Resume;
  logic [31:0] IF_Inst;
  logic [31:0] PC;
  logic [31:0] ID_Inst;
  logic [31:0] ID_PC_plus4;
  logic        ID_Valid;
  logic        Halted;
  logic [31:0] Fetch_count;

  if_fetch_sequencer dut (
    .Clk         (Clk),
    .Clrn        (Clrn),
    .Pcsrc       (Pcsrc),
    .I_jump_PC   (I_jump_PC),
    .ID_Qa       (ID_Qa),
    .J_jump_PC   (J_jump_PC),
    .Stall       (Stall),
    .Halt_req    (Halt_req),
    .Resume      (Resume),
    .IF_Inst     (IF_Inst),
    .PC          (PC),
    .ID_Inst     (ID_Inst),
    .ID_PC_plus4 (ID_PC_plus4),
    .ID_Valid    (ID_Valid),
    .Halted      (Halted),
    .Fetch_count (Fetch_count)
  );

  // Instruction memory stand-in: word content is a fixed function of the address.
  assign IF_Inst = PC ^ IMEM_KEY;

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_valid, m_halted;
  int          m_state;  // 0 run, 1 halt pending, 2 halted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = NOP; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_state = 0;
  endtask

  task automatic drive(input logic [1:0] src, input logic stl, input logic hr, input logic rs);
    Pcsrc = src; Stall = stl; Halt_req = hr; Resume = rs;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, PC, 32'h0);
    chk({tag, "_inst"}, ID_Inst, NOP);
    chk({tag, "_pc4"}, ID_PC_plus4, 32'h0);
    chk({tag, "_valid"}, {31'd0, ID_Valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, Halted}, 32'd0);
    chk({tag, "_cnt"}, Fetch_count, 32'd0);
  endtask

  // Advance the model with the current inputs, push its prediction, clock, then compare.
  task automatic tick(input string tag);
    exp_t        e;
    logic [31:0] nxt;
    if (m_state == 2) begin
      m_inst = NOP; m_valid = 1'b0;
      if (Resume && !Halt_req) m_state = 0;
    end else if (Stall) begin
      if (m_state == 0 && Halt_req) m_state = 1;
    end else begin
      case (Pcsrc)
        2'b00:   nxt = m_pc + 32'd4;
        2'b01:   nxt = I_jump_PC;
        2'b10:   nxt = ID_Qa;
        default: nxt = J_jump_PC;
      endcase
      nxt[1:0] = 2'b00;
      if (Pcsrc == 2'b00) begin
        m_inst = m_pc ^ IMEM_KEY; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end else begin
        m_inst = NOP; m_valid = 1'b0;
      end
      if (m_state == 1 || Halt_req) m_state = 2;
      m_pc = nxt;
    end
    m_halted = (m_state == 2);
    e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4;
    e.valid = m_valid; e.halted = m_halted; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_pc"}, PC, e.pc);
    chk({tag, "_inst"}, ID_Inst, e.inst);
    chk({tag, "_valid"}, {31'd0, ID_Valid}, {31'd0, e.valid});
    chk({tag, "_halted"}, {31'd0, Halted}, {31'd0, e.halted});
    chk({tag, "_cnt"}, Fetch_count, e.cnt);
    if (e.valid) chk({tag, "_pc4"}, ID_PC_plus4, e.pc4);
  endtask

  initial begin
    Clrn = 1'b0;
    I_jump_PC = 32'h0; ID_Qa = 32'h0; J_jump_PC = 32'h0;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #12;
    check_reset_values("reset");
    model_reset();
    @(negedge Clk);
    Clrn = 1'b1;

    // Sequential fetch
    for (int i = 0; i < 4; i++) tick("seq");
    chk("seq_pc_end", PC, 32'h10);
    chk("seq_cnt_end", Fetch_count, 32'd4);

    // Branch redirect: bubble, then target instruction
    I_jump_PC = 32'h40;
    drive(2'b01, 1'b0, 1'b0, 1'b0);
    tick("br");
    chk("br_target", PC, 32'h40);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    tick("br_follow");
    chk("br_follow_pc4", ID_PC_plus4, 32'h44);
    chk("br_follow_inst", ID_Inst, 32'h40 ^ IMEM_KEY);

    // Stall masks a pending J-type redirect
    J_jump_PC = 32'h100;
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    tick("stall0");
    tick("stall1");
    chk("stall_pc_held", PC, 32'h44);
    drive(2'b11, 1'b0, 1'b0, 1'b0);
    tick("j");
    chk("j_target", PC, 32'h100);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    tick("j_follow");

    // Halt requested under stall -> pending -> halted when stall drops
    drive(2'b00, 1'b1, 1'b1, 1'b0);
    tick("hpend0");
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    tick("hpend1");
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    tick("henter");
    chk("henter_halted", {31'd0, Halted}, 32'd1);
    I_jump_PC = 32'h200;
    drive(2'b01, 1'b0, 1'b0, 1'b0);
    tick("halted_ignore_br");
    chk("halted_pc_frozen", PC, 32'h108);
    drive(2'b00, 1'b0, 1'b1, 1'b0);
    tick("halted_hreq_noop");

    // Asynchronous reset while halted, away from any clock edge
    chk("pre_rst_cnt", Fetch_count, 32'd7);
    #3;
    Clrn = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge Clk);
    Clrn = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0);

    // Halt from RUN with simultaneous Resume: halt wins, update applied
    drive(2'b00, 1'b0, 1'b1, 1'b1);
    tick("run_halt_resume");
    tick("halted_both");
    drive(2'b00, 1'b0, 1'b0, 1'b1);
    tick("resume");
    chk("resume_pc_held", PC, 32'h4);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    tick("resume_fetch");
    chk("resume_inst", ID_Inst, 32'h4 ^ IMEM_KEY);

    // Register jump alignment and PC+4 wrap
    ID_Qa = 32'hFFFF_FFFF;
    drive(2'b10, 1'b0, 1'b0, 1'b0);
    tick("jr_top");
    chk("jr_top_pc", PC, 32'hFFFF_FFFC);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    tick("wrap");
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_pc4", ID_PC_plus4, 32'h0);
    ID_Qa = 32'h0000_0123;
    drive(2'b10, 1'b0, 1'b0, 1'b0);
    tick("jr_align");
    chk("jr_align_pc", PC, 32'h120);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    tick("jr_follow");

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
